// File: rtl/psa_accum_if.sv
// psa_accum_if: bundles the batch-control, operand-stream and result-stream
// signals of the PSA sequencing accumulator.
//   start/len          : begin a batch of len operands (sampled in IDLE)
//   in_valid/in_ready  : operand stream, in_data = four signed 4-bit lanes
//   out_valid/out_ready: result stream, out_sum packed sum, out_sat flags
//   busy               : accumulator is not idle
// Modports: master drives the requests/operands/out_ready, slave is the
// accumulator itself.
interface psa_accum_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [3:0]       out_sat;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_sat, busy
  );
endinterface

// File: rtl/psa_accum.sv
// psa_accum: multi-operand accumulator around the 16-bit parallel sub-word
// adder. A batch of len operands is added lane-by-lane (four independent
// signed 4-bit lanes, saturating) into a running sum; the packed result and
// sticky per-lane saturation flags are offered on a valid/ready port.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : psa_accum_if.slave (start/len, in_* stream, out_* stream, busy)
// All outputs decode from registers only; no input-to-output comb path.
module psa_accum #(
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  psa_accum_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      acc_q;
  logic [3:0]       sat_q;

  logic [15:0]      sum_nxt;
  logic [3:0]       ovf_nxt;
  logic             accept;
  logic             launch;

  // Saturating 4-bit lane add. Overflow is detected from sign bits alone:
  // operands agree in sign but the wrapped sum does not. Returns {ovf, sum}.
  function automatic logic [4:0] sat_add4(input logic signed [3:0] a,
                                          input logic signed [3:0] b);
    logic signed [3:0] s;
    logic              ovf;
    s   = a + b;
    ovf = (a[3] == b[3]) && (s[3] != a[3]);
    if (ovf) return {1'b1, (a[3] ? 4'h8 : 4'h7)};
    return {1'b0, s};
  endfunction

  // Lane-wise add of the operand into the accumulator; no inter-lane carry.
  always_comb begin
    logic [4:0] r;
    sum_nxt = '0;
    ovf_nxt = '0;
    r       = '0;
    for (int i = 0; i < 4; i++) begin
      r                = sat_add4(acc_q[4*i +: 4], bus.in_data[4*i +: 4]);
      sum_nxt[4*i +: 4] = r[3:0];
      ovf_nxt[i]        = r[4];
    end
  end

  assign launch = (state_q == IDLE)  && bus.start;
  assign accept = (state_q == ACCUM) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len != '0) ? ACCUM : DONE;
      ACCUM:   if (bus.in_valid && (cnt_q == CNT_W'(1))) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Accumulator, sticky flags and remaining count. A saturated lane keeps
  // accumulating from its clamped value; its flag clears only on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      sat_q <= '0;
    end else if (launch) begin
      cnt_q <= bus.len;
      acc_q <= '0;
      sat_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= sum_nxt;
      sat_q <= sat_q | ovf_nxt;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_psa_accum.sv
// Bench for psa_accum: table of batches plus a few hand-written sequences
// (mid-batch reset). Expected results go into a scoreboard queue when a
// batch is driven and are popped when the DUT raises out_valid.
module tb_psa_accum;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  psa_accum_if #(.CNT_W(CNT_W)) bus ();

  psa_accum #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  sat;
  } res_t;

  typedef struct {
    logic [3:0]        len;
    logic [7:0][15:0]  ops;
    int                gap;       // idle cycles before each operand
    int                hold;      // cycles out_ready stays low in DONE
    bit                poke;      // pulse start while in DONE
    logic [15:0]       exp_sum;
    logic [3:0]        exp_sat;
  } vec_t;

  res_t sbq[$];
  vec_t tbl[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference lane arithmetic with integer sums and explicit clamping.
  function automatic res_t model(input logic [3:0] l, input logic [7:0][15:0] ops);
    res_t r;
    int   lane [4];
    logic signed [3:0] v4;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < 4; i++) lane[i] = 0;
    for (int k = 0; k < int'(l); k++) begin
      for (int i = 0; i < 4; i++) begin
        int v;
        v4 = ops[k][4*i +: 4];
        v  = lane[i] + int'(v4);
        if (v > 7)       begin v = 7;  r.sat[i] = 1'b1; end
        else if (v < -8) begin v = -8; r.sat[i] = 1'b1; end
        lane[i] = v;
      end
    end
    for (int i = 0; i < 4; i++) begin
      t = lane[i];
      r.sum[4*i +: 4] = t[3:0];
    end
    return r;
  endfunction

  task automatic run_batch(input vec_t v, input string tag);
    res_t exp, held;
    int   waited;
    exp.sum = v.exp_sum;
    exp.sat = v.exp_sat;
    sbq.push_back(exp);
    bus.start = 1'b1;
    bus.len   = v.len;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 4'hF;
    chk({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    chk({tag, " in_ready after start"}, 32'(bus.in_ready), 32'(v.len != 0));
    for (int k = 0; k < int'(v.len); k++) begin
      for (int g = 0; g < v.gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hFFFF;
        @(negedge clk);
      end
      chk({tag, " no out_valid before last"}, 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = v.ops[k];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk({tag, " out_valid right after last"}, 32'(bus.out_valid), 32'd1);
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.out_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s out_valid timeout: got 0 expected 1", tag);
      void'(sbq.pop_front());
      return;
    end
    exp = sbq.pop_front();
    chk({tag, " out_sum"}, 32'(bus.out_sum), 32'(exp.sum));
    chk({tag, " out_sat"}, 32'(bus.out_sat), 32'(exp.sat));
    held.sum = bus.out_sum;
    held.sat = bus.out_sat;
    for (int h = 0; h < v.hold; h++) begin
      bus.start = v.poke;
      bus.len   = 4'h0;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " hold out_sum/sat"}, 32'({bus.out_sum, bus.out_sat}), 32'({held.sum, held.sat}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " busy after handshake"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " busy"},      32'(bus.busy),      32'd0);
    chk({tag, " out_sum"},   32'(bus.out_sum),   32'd0);
    chk({tag, " out_sat"},   32'(bus.out_sat),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    res_t m;
    tbl[0] = '{len: 4'd1, ops: {112'h0, 16'h1234}, gap: 0, hold: 0, poke: 0,
               exp_sum: 16'h1234, exp_sat: 4'b0000};
    tbl[1] = '{len: 4'd2, ops: {96'h0, 16'h1F11, 16'h7123}, gap: 0, hold: 0, poke: 0,
               exp_sum: 16'h7034, exp_sat: 4'b1000};
    tbl[2] = '{len: 4'd2, ops: {96'h0, 16'hF000, 16'h8000}, gap: 0, hold: 0, poke: 0,
               exp_sum: 16'h8000, exp_sat: 4'b1000};
    tbl[3] = '{len: 4'd3, ops: {80'h0, 16'h000F, 16'h0001, 16'h0007}, gap: 0, hold: 0, poke: 0,
               exp_sum: 16'h0006, exp_sat: 4'b0001};
    tbl[4] = '{len: 4'd3, ops: {80'h0, 16'h1111, 16'h1111, 16'h1111}, gap: 2, hold: 5, poke: 1,
               exp_sum: 16'h3333, exp_sat: 4'b0000};
    tbl[5] = '{len: 4'd0, ops: '0, gap: 0, hold: 0, poke: 0,
               exp_sum: 16'h0000, exp_sat: 4'b0000};

    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_batch(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-batch after one of three operands.
    bus.start = 1'b1; bus.len = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h2222;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midreset acc before", 32'(bus.out_sum), 32'h2222);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_batch(tbl[5], "len0");

    for (int r = 0; r < 4; r++) begin
      rv.len = 4'($urandom_range(1, 7));
      for (int k = 0; k < 8; k++) rv.ops[k] = 16'($urandom);
      rv.gap = r % 2; rv.hold = r; rv.poke = 0;
      m = model(rv.len, rv.ops);
      rv.exp_sum = m.sum; rv.exp_sat = m.sat;
      run_batch(rv, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
